// File: rtl/sevenseg_mux.sv
// sevenseg_mux: time-multiplexed common-anode seven-segment driver.
// Captures data/dp_in/blank into a shadow buffer once per frame and scans
// the digits with an anode-off guard interval at the start of every slot.
// Optional feature macro: SEVENSEG_LZB_EN enables leading-zero blanking.
module sevenseg_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            segs_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

  logic [CW-1:0]         r_div_cnt;
  logic [DW-1:0]         r_dig;
  logic [4*DIGITS-1:0]   r_sh_data;
  logic [DIGITS-1:0]     r_sh_dp;
  logic [DIGITS-1:0]     r_sh_blank;
  logic                  r_valid;
  logic [6:0]            r_segs_n;
  logic                  r_dp_n;
  logic [DIGITS-1:0]     r_an_n;
  logic                  r_frame_tick;

  logic                  w_cnt_last;
  logic                  w_dig_last;
  logic                  w_frame_wrap;
  logic [3:0]            w_nib;
  logic                  w_sel_dp;
  logic                  w_sel_blank;
  logic                  w_sel_lz;
  logic                  w_supp;
  logic                  w_guard_ok;
  logic                  w_en;
  logic [6:0]            w_seg;
  logic [DIGITS-1:0]     w_an_sel;
  logic [6:0]            w_segs_nx;
  logic                  w_dp_nx;
  logic [DIGITS-1:0]     w_an_nx;
  logic [DIGITS-1:0]     w_lz;

  assign w_cnt_last   = (r_div_cnt == CNT_LAST);
  assign w_dig_last   = (r_dig == DIG_LAST);
  assign w_frame_wrap = w_cnt_last & w_dig_last;
  assign w_an_sel     = ~(DIGITS'(1) << r_dig);

  // Guard comparison collapses to constant-true when there is no guard
  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_guard_ok = 1'b1;
    end else begin : g_guard
      assign w_guard_ok = (r_div_cnt >= CW'(GUARD));
    end
  endgenerate

  // Refresh divider and digit scan counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_dig     <= '0;
    end else if (w_cnt_last) begin
      r_div_cnt <= '0;
      r_dig     <= w_dig_last ? '0 : r_dig + DW'(1);
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  // Shadow capture at frame wrap; r_valid keeps the display dark until the first capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
      r_valid    <= 1'b0;
    end else if (w_frame_wrap) begin
      r_sh_data  <= data;
      r_sh_dp    <= dp_in;
      r_sh_blank <= blank;
      r_valid    <= 1'b1;
    end
  end

`ifdef SEVENSEG_LZB_EN
  // Leading-zero map: bit k set when nibbles k..DIGITS-1 are all zero
  always_comb begin
    logic acc;
    acc  = 1'b1;
    w_lz = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      acc      = acc & (r_sh_data[4*k +: 4] == 4'h0);
      w_lz[k]  = acc;
    end
  end
  assign w_supp = (r_dig != '0) & w_sel_lz;
`else
  assign w_lz   = '0;
  assign w_supp = 1'b0;
`endif

  // Select the shadow fields for the active slot
  always_comb begin
    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    w_sel_lz    = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_dig == DW'(k)) begin
        w_nib       = r_sh_data[4*k +: 4];
        w_sel_dp    = r_sh_dp[k];
        w_sel_blank = r_sh_blank[k];
        w_sel_lz    = w_lz[k];
      end
    end
  end

  // Hex to active-high segments, bit 6 = a .. bit 0 = g
  always_comb begin
    w_seg = 7'b0000000;
    case (w_nib)
      4'h0: w_seg = 7'b1111110;
      4'h1: w_seg = 7'b0110000;
      4'h2: w_seg = 7'b1101101;
      4'h3: w_seg = 7'b1111001;
      4'h4: w_seg = 7'b0110011;
      4'h5: w_seg = 7'b1011011;
      4'h6: w_seg = 7'b1011111;
      4'h7: w_seg = 7'b1110000;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1111011;
      4'hA: w_seg = 7'b1110111;
      4'hB: w_seg = 7'b0011111;
      4'hC: w_seg = 7'b1001110;
      4'hD: w_seg = 7'b0111101;
      4'hE: w_seg = 7'b1001111;
      4'hF: w_seg = 7'b1000111;
      default: w_seg = 7'b0000000;
    endcase
  end

  // Next output values; a suppressed leading zero may still light its point
  always_comb begin
    w_an_nx   = '1;
    w_segs_nx = '1;
    w_dp_nx   = 1'b1;
    w_en      = r_valid & w_guard_ok & ~w_sel_blank;
    if (w_en && !w_supp) begin
      w_an_nx   = w_an_sel;
      w_segs_nx = ~w_seg;
      w_dp_nx   = ~w_sel_dp;
    end else if (w_en && w_supp && w_sel_dp) begin
      w_an_nx   = w_an_sel;
      w_dp_nx   = 1'b0;
    end
  end

  // Registered outputs, one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_n       <= '1;
      r_segs_n     <= '1;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an_n       <= w_an_nx;
      r_segs_n     <= w_segs_nx;
      r_dp_n       <= w_dp_nx;
      r_frame_tick <= w_frame_wrap;
    end
  end

  assign segs_n     = r_segs_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Self-checking bench for sevenseg_mux with DIGITS=4, REFRESH_DIV=4, GUARD=1.
module tb_sevenseg_mux;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned RDIV   = 4;
  localparam int unsigned GRD    = 1;
  localparam int unsigned NVEC   = 6;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  lit;   // which slots light their anode
    logic [27:0] segs;  // expected segs_n, digit k at [7k+:7]
    logic [3:0]  dpn;   // expected dp_n per lit digit
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] segs;
    logic       dpn;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [6:0]  segs_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_tests;
  int n_fail;
  vec_t vecs [NVEC];
  exp_t q [$];

  sevenseg_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .GUARD(GRD)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank),
    .segs_n(segs_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic apply(input vec_t v);
    data  = v.data;
    dp_in = v.dp;
    blank = v.blank;
  endtask

  task automatic wait_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_tick: frame_tick=0 after 40 cycles, want a pulse");
    end
  endtask

  // Expect 15 cycles following a capture; optionally change data mid slot 2
  task automatic check_frame(input vec_t v, input bit chg, input logic [15:0] nd);
    exp_t e;
    for (int t = 1; t <= 15; t++) begin
      int k;
      int pos;
      k   = (t - 1) / 4;
      pos = (t - 1) % 4;
      e.an = 4'hF; e.segs = 7'h7F; e.dpn = 1'b1;
      if (pos != 0 && v.lit[k]) begin
        e.an   = ~(4'b0001 << k);
        e.segs = v.segs[7*k +: 7];
        e.dpn  = v.dpn[k];
      end
      q.push_back(e);
    end
    for (int t = 1; t <= 15; t++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_tests++;
      if (an_n !== e.an || segs_n !== e.segs || dp_n !== e.dpn || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL frame data=%h t=%0d: got an_n=%b segs_n=%b dp_n=%b tick=%b, want %b %b %b 0",
                 v.data, t, an_n, segs_n, dp_n, frame_tick, e.an, e.segs, e.dpn);
      end
      if (chg && t == 10) data = nd;
    end
  endtask

  task automatic do_reset(input int hold);
    int found;
    rst = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      n_tests++;
      if (an_n !== 4'hF || segs_n !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_vals: got an_n=%b segs_n=%b dp_n=%b tick=%b, want 1111 1111111 1 0",
                 an_n, segs_n, dp_n, frame_tick);
      end
    end
    rst = 1'b0;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (an_n !== 4'hF || segs_n !== 7'h7F || dp_n !== 1'b1) begin
        n_fail++;
        $display("FAIL dark_before_capture k=%0d: got an_n=%b segs_n=%b dp_n=%b, want 1111 1111111 1",
                 k, an_n, segs_n, dp_n);
      end
      if (frame_tick) begin
        found = k;
        break;
      end
    end
    n_tests++;
    if (found != 16) begin
      n_fail++;
      $display("FAIL first_tick_latency: got %0d cycles, want 16", found);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    data  = '0;
    dp_in = '0;
    blank = '0;

    vecs[0] = '{data:16'hA5C0, dp:4'b0000, blank:4'b0000, lit:4'b1111,
                segs:{7'b0001000, 7'b0100100, 7'b0110001, 7'b0000001}, dpn:4'b1111};
    vecs[1] = '{data:16'h1234, dp:4'b0000, blank:4'b0000, lit:4'b1111,
                segs:{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, dpn:4'b1111};
    vecs[2] = '{data:16'h8F9E, dp:4'b0010, blank:4'b0100, lit:4'b1011,
                segs:{7'b0000000, 7'b1111111, 7'b0000100, 7'b0110000}, dpn:4'b1101};
`ifdef SEVENSEG_LZB_EN
    vecs[3] = '{data:16'h0070, dp:4'b1000, blank:4'b0000, lit:4'b1011,
                segs:{7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}, dpn:4'b0111};
    vecs[5] = '{data:16'h0000, dp:4'b1111, blank:4'b1001, lit:4'b0110,
                segs:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, dpn:4'b1001};
`else
    vecs[3] = '{data:16'h0070, dp:4'b1000, blank:4'b0000, lit:4'b1111,
                segs:{7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}, dpn:4'b0111};
    vecs[5] = '{data:16'h0000, dp:4'b1111, blank:4'b1001, lit:4'b0110,
                segs:{7'b1111111, 7'b0000001, 7'b0000001, 7'b1111111}, dpn:4'b1001};
`endif
    vecs[4] = '{data:16'h6BD3, dp:4'b0101, blank:4'b0000, lit:4'b1111,
                segs:{7'b0100000, 7'b1100000, 7'b1000010, 7'b0000110}, dpn:4'b1010};

    // Power-on reset held 3 cycles, then first capture latency
    do_reset(3);

    // Table-driven frames
    for (int i = 0; i < int'(NVEC); i++) begin
      apply(vecs[i]);
      wait_tick();
      check_frame(vecs[i], 1'b0, 16'h0000);
    end

    // Mid-frame data change stays invisible until the next capture
    apply(vecs[0]);
    wait_tick();
    check_frame(vecs[0], 1'b1, 16'h1234);
    wait_tick();
    check_frame(vecs[1], 1'b0, 16'h0000);

    // Reset asserted during slot 2 aborts the scan, which restarts at digit 0
    apply(vecs[2]);
    wait_tick();
    repeat (10) begin
      @(posedge clk); #1;
    end
    do_reset(1);
    check_frame(vecs[2], 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
